// File: rtl/irq_controller.sv
// Interrupt controller: per-source enable, level/edge mode, routing to CPU lines
// and a claim register returning the lowest-index enabled pending source.
module irq_controller #(
  parameter int N_SRC     = 8,
  parameter int IRQ_LINES = 6,
  parameter int ROUTE_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SRC-1:0]     src,
  input  logic [31:0]          address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          data_wr,
  input  logic [3:0]           mask,
  output logic                 stall,
  output logic [31:0]          data_rd,
  output logic [31:0]          data_rd_2,
  output logic [IRQ_LINES-1:0] interrupt
);

  localparam int RT_BITS = N_SRC * ROUTE_W;

  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_ENABLE   = 3'd1,
    REG_MODE     = 3'd2,
    REG_SOFT_SET = 3'd3,
    REG_ROUTE    = 3'd4,
    REG_CLAIM    = 3'd5,
    REG_RSVD6    = 3'd6,
    REG_RSVD7    = 3'd7
  } reg_e;

  logic [N_SRC-1:0]     sync1_q, sync1_d;
  logic [N_SRC-1:0]     src_s_q, src_s_d;
  logic [N_SRC-1:0]     src_d_q, src_d_d;
  logic [N_SRC-1:0]     pend_q, pend_d;
  logic [N_SRC-1:0]     enable_q, enable_d;
  logic [N_SRC-1:0]     mode_q, mode_d;
  logic [RT_BITS-1:0]   route_q, route_d;
  logic [IRQ_LINES-1:0] interrupt_q, interrupt_d;

  reg_e             reg_idx;
  logic [31:0]      wmask;
  logic [31:0]      wr_bits;
  logic [N_SRC-1:0] eff_pend;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] claim_onehot;
  logic [3:0]       claim_idx;
  logic             claim_valid;
  logic             claim_fire;
  logic [N_SRC-1:0] set_v;
  logic [N_SRC-1:0] clr_v;
  logic             unused_bits;

  assign unused_bits = ^{address[31:5], address[1:0], data_wr, wmask, wr_bits};

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    reg_idx  = reg_e'(address[4:2]);
    wmask    = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    wr_bits  = data_wr & wmask;

    // A level source shows its synchronised input; an edge source its latch.
    eff_pend = (mode_q & pend_q) | (~mode_q & src_s_q);
    active   = eff_pend & enable_q;

    claim_valid  = |active;
    claim_onehot = active & ~(active - 1'b1);
    claim_idx    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) claim_idx = 4'(i);
    end
    claim_fire = read && (reg_idx == REG_CLAIM) && claim_valid;

    sync1_d = src;
    src_s_d = sync1_q;
    src_d_d = src_s_q;

    enable_d = enable_q;
    mode_d   = mode_q;
    route_d  = route_q;
    if (write) begin
      unique case (reg_idx)
        REG_ENABLE: enable_d = (enable_q & ~wmask[N_SRC-1:0]) | wr_bits[N_SRC-1:0];
        REG_MODE:   mode_d   = (mode_q & ~wmask[N_SRC-1:0]) | wr_bits[N_SRC-1:0];
        REG_ROUTE:  route_d  = (route_q & ~wmask[RT_BITS-1:0]) | wr_bits[RT_BITS-1:0];
        default: ;
      endcase
    end

    set_v = src_s_q & ~src_d_q;
    if (write && reg_idx == REG_SOFT_SET) set_v = set_v | wr_bits[N_SRC-1:0];
    clr_v = claim_fire ? claim_onehot : '0;
    if (write && reg_idx == REG_STATUS) clr_v = clr_v | wr_bits[N_SRC-1:0];

    // Set beats clear; anything leaving (or staying in) level mode is held clear.
    pend_d = (set_v | (pend_q & ~clr_v)) & mode_d;

    interrupt_d = '0;
    for (int l = 0; l < IRQ_LINES; l++) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (active[i] && route_q[i*ROUTE_W +: ROUTE_W] == ROUTE_W'(l)) interrupt_d[l] = 1'b1;
      end
    end

    data_rd = '0;
    unique case (reg_idx)
      REG_STATUS: data_rd = 32'(eff_pend);
      REG_ENABLE: data_rd = 32'(enable_q);
      REG_MODE:   data_rd = 32'(mode_q);
      REG_ROUTE:  data_rd = 32'(route_q);
      REG_CLAIM:  data_rd = {claim_valid, 27'd0, claim_idx};
      default:    data_rd = '0;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      src_s_q     <= '0;
      src_d_q     <= '0;
      pend_q      <= '0;
      enable_q    <= '0;
      mode_q      <= '0;
      route_q     <= '0;
      interrupt_q <= '0;
    end else begin
      sync1_q     <= sync1_d;
      src_s_q     <= src_s_d;
      src_d_q     <= src_d_d;
      pend_q      <= pend_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      route_q     <= route_d;
      interrupt_q <= interrupt_d;
    end
  end

  assign interrupt = interrupt_q;
  assign stall     = 1'b0;
  assign data_rd_2 = '0;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: register table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_irq_controller;

  localparam int N  = 8;
  localparam int L  = 6;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  src;
  logic [31:0]   address;
  logic          read;
  logic          write;
  logic [31:0]   data_wr;
  logic [3:0]    mask;
  logic          stall;
  logic [31:0]   data_rd;
  logic [31:0]   data_rd_2;
  logic [L-1:0]  interrupt;

  int n_checks = 0;
  int n_fail   = 0;

  irq_controller #(.N_SRC(N), .IRQ_LINES(L), .ROUTE_W(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src       (src),
    .address   (address),
    .read      (read),
    .write     (write),
    .data_wr   (data_wr),
    .mask      (mask),
    .stall     (stall),
    .data_rd   (data_rd),
    .data_rd_2 (data_rd_2),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit [N-1:0] m_s1, m_s2, m_d, m_pend, m_en, m_mode;
  int         m_route[N];
  bit [L-1:0] m_irq;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_d = '0; m_pend = '0; m_en = '0; m_mode = '0; m_irq = '0;
    for (int i = 0; i < N; i++) m_route[i] = 0;
  endtask

  function automatic bit m_eff(int i);
    return m_mode[i] ? m_pend[i] : m_s2[i];
  endfunction

  function automatic int m_claim_src();
    for (int i = 0; i < N; i++) if (m_eff(i) && m_en[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(int idx);
    logic [31:0] v;
    int c;
    v = 0;
    case (idx)
      0: for (int i = 0; i < N; i++) if (m_eff(i)) v = v + (32'd1 << i);
      1: v = 32'(m_en);
      2: v = 32'(m_mode);
      4: for (int i = 0; i < N; i++) v = v + (32'(m_route[i]) << (i * RW));
      5: begin
        c = m_claim_src();
        if (c >= 0) v = 32'h8000_0000 + 32'(c);
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic model_step();
    int         idx, c, p;
    logic [31:0] wm;
    bit [L-1:0] irq_n;
    bit [N-1:0] en_n, mode_n, pend_n;
    int         route_n[N];
    bit         set, clr;
    idx = int'(address[4:2]);
    for (int b = 0; b < 32; b++) wm[b] = mask[b / 8];
    c = m_claim_src();
    irq_n = '0;
    for (int i = 0; i < N; i++)
      if (m_eff(i) && m_en[i] && m_route[i] < L) irq_n[m_route[i]] = 1'b1;
    en_n = m_en; mode_n = m_mode; route_n = m_route;
    if (write) begin
      for (int i = 0; i < N; i++) begin
        if (idx == 1 && wm[i]) en_n[i] = data_wr[i];
        if (idx == 2 && wm[i]) mode_n[i] = data_wr[i];
        if (idx == 4) begin
          for (int b = 0; b < RW; b++) begin
            p = i * RW + b;
            if (wm[p]) route_n[i] = data_wr[p] ? (route_n[i] | (1 << b)) : (route_n[i] & ~(1 << b));
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      set = (m_s2[i] && !m_d[i]) || (write && idx == 3 && data_wr[i] && wm[i]);
      clr = (write && idx == 0 && data_wr[i] && wm[i]) || (read && idx == 5 && c == i);
      if (!mode_n[i])  pend_n[i] = 1'b0;
      else if (set)    pend_n[i] = 1'b1;
      else if (clr)    pend_n[i] = 1'b0;
      else             pend_n[i] = m_pend[i];
    end
    m_irq = irq_n; m_d = m_s2; m_s2 = m_s1; m_s1 = src;
    m_en = en_n; m_mode = mode_n; m_route = route_n; m_pend = pend_n;
  endtask

  // ---------------- helpers ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; src = '0; read = 0; write = 0; address = '0; data_wr = '0; mask = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic bus_write(int idx, logic [31:0] d, logic [3:0] m);
    address = 32'(idx) << 2; data_wr = d; mask = m; write = 1'b1;
    tick();
    write = 1'b0; mask = '0;
  endtask

  task automatic bus_read_check(int idx, logic [31:0] exp, string name);
    address = 32'(idx) << 2; read = 1'b1;
    #1 check(name, data_rd, exp);
    tick();
    read = 1'b0;
  endtask

  // ---------------- register table ----------------
  typedef struct {
    bit          do_wr;
    int          w_idx;
    logic [31:0] w_data;
    logic [3:0]  w_mask;
    int          r_idx;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(bit w, int wi, logic [31:0] wd, logic [3:0] wm, int ri,
                              logic [31:0] e, string n);
    vec_t v;
    v.do_wr = w; v.w_idx = wi; v.w_data = wd; v.w_mask = wm;
    v.r_idx = ri; v.exp = e; v.name = n;
    return v;
  endfunction

  int age[N];

  initial begin
    tbl[0]  = mk(0, 0, 0,            4'hF, 0, 32'h0,        "rst_status");
    tbl[1]  = mk(0, 0, 0,            4'hF, 1, 32'h0,        "rst_enable");
    tbl[2]  = mk(1, 1, 32'hFFFF_FFFF, 4'hF, 1, 32'h0000_00FF, "enable_all");
    tbl[3]  = mk(1, 1, 32'h1234_5678, 4'h1, 1, 32'h0000_0078, "enable_byte0");
    tbl[4]  = mk(1, 2, 32'h0000_00AA, 4'h0, 2, 32'h0,        "mode_nomask");
    tbl[5]  = mk(1, 2, 32'h0000_005A, 4'h1, 2, 32'h0000_005A, "mode_byte0");
    tbl[6]  = mk(1, 4, 32'hFFFF_FFFF, 4'hF, 4, 32'h00FF_FFFF, "route_all");
    tbl[7]  = mk(1, 4, 32'h0012_3456, 4'h2, 4, 32'h00FF_34FF, "route_byte1");
    tbl[8]  = mk(1, 4, 32'h00AB_CDEF, 4'h4, 4, 32'h00AB_34FF, "route_byte2");
    tbl[9]  = mk(1, 3, 32'h0000_0002, 4'hF, 3, 32'h0,        "softset_reads0");
    tbl[10] = mk(0, 0, 0,            4'hF, 0, 32'h0000_0002, "status_soft");
    tbl[11] = mk(0, 0, 0,            4'hF, 5, 32'h0,        "claim_disabled");
    tbl[12] = mk(1, 7, 32'hFFFF_FFFF, 4'hF, 7, 32'h0,        "rsvd7");
    tbl[13] = mk(1, 6, 32'hFFFF_FFFF, 4'hF, 6, 32'h0,        "rsvd6");
    tbl[14] = mk(1, 1, 32'h0000_0002, 4'hF, 5, 32'h8000_0001, "claim_src1");
    tbl[15] = mk(0, 0, 0,            4'hF, 0, 32'h0,        "status_claimed");
    tbl[16] = mk(1, 2, 32'h0,        4'hF, 2, 32'h0,        "mode_clear");

    do_reset();
    #1 check("stall", 32'(stall), 32'h0);
    check("data_rd_2", data_rd_2, 32'h0);
    check("rst_irq", 32'(interrupt), 32'h0);

    for (int t = 0; t < 17; t++) begin
      if (tbl[t].do_wr) bus_write(tbl[t].w_idx, tbl[t].w_data, tbl[t].w_mask);
      bus_read_check(tbl[t].r_idx, tbl[t].exp, tbl[t].name);
    end

    // Level source 0 -> line 0, exact latency both ways.
    do_reset();
    bus_write(1, 32'h01, 4'hF);
    src[0] = 1'b1;
    tick(); tick();
    check("lvl_rise_k1", 32'(interrupt), 32'h00);
    tick();
    check("lvl_rise_k2", 32'(interrupt), 32'h01);
    bus_read_check(5, 32'h8000_0000, "lvl_claim");
    src[0] = 1'b0;
    tick(); tick();
    check("lvl_fall_k1", 32'(interrupt), 32'h01);
    tick();
    check("lvl_fall_k2", 32'(interrupt), 32'h00);

    // Edge source 2 routed to line 5, latched past the pulse, cleared by W1C.
    bus_write(4, 32'h0000_0140, 4'hF);
    bus_write(2, 32'h04, 4'hF);
    bus_write(1, 32'h04, 4'hF);
    src[2] = 1'b1;
    tick(); tick(); tick();
    check("edge_k2", 32'(interrupt), 32'h00);
    src[2] = 1'b0;
    tick();
    check("edge_k3", 32'(interrupt), 32'h20);
    tick(); tick(); tick();
    check("edge_held", 32'(interrupt), 32'h20);
    bus_read_check(0, 32'h04, "edge_status");
    bus_write(0, 32'h04, 4'hF);
    tick();
    check("w1c_irq", 32'(interrupt), 32'h00);
    bus_read_check(0, 32'h0, "w1c_status");

    // Claim ordering between two edge sources.
    do_reset();
    bus_write(2, 32'h0A, 4'hF);
    bus_write(1, 32'h0A, 4'hF);
    src = 8'h0A;
    tick(); tick(); tick();
    src = '0;
    tick(); tick(); tick();
    bus_read_check(5, 32'h8000_0001, "claim_first");
    bus_read_check(5, 32'h8000_0003, "claim_second");
    bus_read_check(5, 32'h0, "claim_empty");

    // W1C coinciding with a rise: the set wins.
    src[3] = 1'b1;
    tick(); tick();
    bus_write(0, 32'h08, 4'hF);
    bus_read_check(0, 32'h08, "w1c_vs_rise");
    src[3] = 1'b0;

    // SOFT_SET byte masking and enable gating.
    do_reset();
    bus_write(2, 32'h10, 4'hF);
    bus_write(3, 32'h10, 4'h0);
    bus_read_check(0, 32'h0, "softset_nomask");
    bus_write(3, 32'h10, 4'h1);
    bus_read_check(0, 32'h10, "softset_mask");
    tick(); tick();
    check("softset_disabled", 32'(interrupt), 32'h00);
    bus_write(1, 32'h10, 4'hF);
    tick();
    check("softset_enabled", 32'(interrupt), 32'h01);

    // Reset in the middle of activity.
    bus_write(2, 32'hFF, 4'hF);
    bus_write(1, 32'hFF, 4'hF);
    bus_write(3, 32'hFF, 4'hF);
    tick();
    check("pre_reset_irq", 32'(interrupt), 32'h01);
    rst_n = 1'b0;
    #1 check("async_reset_irq", 32'(interrupt), 32'h00);
    do_reset();
    for (int r = 0; r < 8; r++) bus_read_check(r, 32'h0, $sformatf("post_reset_r%0d", r));

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < N; i++) age[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        age[i]++;
        if (age[i] >= 2 && $urandom_range(0, 5) == 0) begin
          src[i] = ~src[i];
          age[i] = 0;
        end
      end
      read = 0; write = 0;
      address = {$urandom} & 32'hFFFF_FFE3 | (32'($urandom_range(0, 7)) << 2);
      data_wr = $urandom;
      mask = 4'($urandom);
      case ($urandom_range(0, 3))
        0: read = 1'b1;
        1: write = 1'b1;
        default: ;
      endcase
      #1;
      if (read) check("rand_rd", data_rd, m_read(int'(address[4:2])));
      tick();
      check("rand_irq", 32'(interrupt), 32'(m_irq));
    end
    read = 0; write = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
